// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: main/side/pedestrian signal ring with cycle-counted phases and latched walk requests
module intersection_phase_scheduler #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 16,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int WALK      = 6,
  parameter int CNT_W     = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       side_car,
  input  logic       ped_req,
  output logic       main_red,
  output logic       main_yellow,
  output logic       main_green,
  output logic       side_red,
  output logic       side_yellow,
  output logic       side_green,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    MAIN_G = 3'd0, MAIN_Y = 3'd1, RED_A = 3'd2, PED = 3'd3,
    SIDE_G = 3'd4, SIDE_Y = 3'd5, RED_B = 3'd6, BAD = 3'd7
  } phase_t;
  localparam logic [CNT_W-1:0] T_MIN  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] T_RED  = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK - 1);
  phase_t st, nxt;
  logic [CNT_W-1:0] timer;
  logic ped_pending, enter_walk, min_ok;
  assign min_ok = timer >= T_MIN;
  always_comb begin
    nxt = st;
    case (st)
      MAIN_G:  nxt = (min_ok && (side_car || ped_pending)) ? MAIN_Y : MAIN_G;
      MAIN_Y:  nxt = (timer == T_YEL) ? RED_A : MAIN_Y;
      RED_A:   nxt = (timer == T_RED) ? (ped_pending ? PED : SIDE_G) : RED_A;
      PED:     nxt = (timer == T_WALK) ? (side_car ? SIDE_G : RED_B) : PED;
      SIDE_G:  nxt = ((min_ok && !side_car) || timer == T_MAX) ? SIDE_Y : SIDE_G;
      SIDE_Y:  nxt = (timer == T_YEL) ? RED_B : SIDE_Y;
      RED_B:   nxt = (timer == T_RED) ? MAIN_G : RED_B;
      default: nxt = MAIN_G;
    endcase
  end
  assign enter_walk = nxt == PED && st != PED;
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= MAIN_G;
      timer       <= '0;
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      st          <= nxt;
      timer       <= (nxt != st) ? '0 : (&timer ? timer : timer + CNT_W'(1));
      // a request landing in or on entry to WALK is served by that walk and dropped
      ped_pending <= !enter_walk && (ped_pending || (ped_req && st != PED));
      ped_ack     <= !ped_pending && !enter_walk && ped_req && st != PED;
    end
  end
  assign main_green  = st == MAIN_G;
  assign main_yellow = st == MAIN_Y;
  assign main_red    = !(main_green || main_yellow);
  assign side_green  = st == SIDE_G;
  assign side_yellow = st == SIDE_Y;
  assign side_red    = !(side_green || side_yellow);
  assign walk        = st == PED;
  assign phase       = st;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb_intersection_phase_scheduler: directed runs checked against a per-cycle rule model plus literal phase sequences
module tb_intersection_phase_scheduler;
  logic clock = 1'b0, reset = 1'b1, side_car = 1'b0, ped_req = 1'b0;
  logic main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk, ped_ack;
  logic [2:0] phase;
  int vectors = 0, miscompares = 0;
  bit armed = 1'b0;
  int m_ph = 0, m_el = 0;
  bit m_pend = 1'b0, m_ack = 1'b0;
  int dur [7] = '{8, 3, 1, 6, 8, 3, 1};

  intersection_phase_scheduler dut (
    .clock(clock), .reset(reset), .side_car(side_car), .ped_req(ped_req),
    .main_red(main_red), .main_yellow(main_yellow), .main_green(main_green),
    .side_red(side_red), .side_yellow(side_yellow), .side_green(side_green),
    .walk(walk), .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clock = ~clock;

  // rule model: m_el counts completed cycles in the current phase
  always @(posedge clock) begin
    int nx;
    bit up, enter;
    if (reset) begin
      m_ph = 0; m_el = 0; m_pend = 0; m_ack = 0;
    end else begin
      up = (m_el + 1 >= dur[m_ph]);
      nx = m_ph;
      if (m_ph == 0 && up && (side_car || m_pend)) nx = 1;
      else if (m_ph == 1 && up) nx = 2;
      else if (m_ph == 2 && up) nx = m_pend ? 3 : 4;
      else if (m_ph == 3 && up) nx = side_car ? 4 : 6;
      else if (m_ph == 4 && ((up && !side_car) || m_el + 1 == 16)) nx = 5;
      else if (m_ph == 5 && up) nx = 6;
      else if (m_ph == 6 && up) nx = 0;
      enter = (nx == 3 && m_ph != 3);
      m_ack = !m_pend && !enter && ped_req && m_ph != 3;
      m_pend = !enter && (m_pend || (ped_req && m_ph != 3));
      m_el = (nx != m_ph) ? 0 : m_el + 1;
      m_ph = nx;
    end
  end

  always @(negedge clock) begin
    logic [10:0] act, exp;
    if (armed) begin
      act = {phase, main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk, ped_ack};
      exp = {3'(m_ph), m_ph != 0 && m_ph != 1, m_ph == 1, m_ph == 0,
             m_ph != 4 && m_ph != 5, m_ph == 5, m_ph == 4, m_ph == 3, m_ack};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL model t=%0t got=%b want=%b (phase,mr,my,mg,sr,sy,sg,walk,ack)", $time, act, exp);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  task automatic run(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      chk("phase_run", int'(phase), p);
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; side_car = 1'b0; ped_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    armed = 1'b1;
    chk("reset_phase", int'(phase), 0);
    chk("reset_lamps", int'({main_green, side_red, walk, ped_ack}), 4'b1100);
    run(0, 100);

    do_reset();
    side_car = 1'b1;
    run(0, 8); run(1, 3); run(2, 1); run(4, 16); run(5, 3); run(6, 1); run(0, 2);

    do_reset();
    side_car = 1'b1;
    run(0, 8); run(1, 3); run(2, 1); run(4, 3);
    side_car = 1'b0;
    run(4, 5); run(5, 3); run(6, 1); run(0, 5);

    do_reset();
    side_car = 1'b1;
    run(0, 7);
    side_car = 1'b0;
    run(0, 12);

    do_reset();
    run(0, 3);
    ped_req = 1'b1;
    chk("ack_before", int'(ped_ack), 0);
    step();
    ped_req = 1'b0;
    chk("ack_pulse", int'(ped_ack), 1);
    run(0, 4); run(1, 3); run(2, 1); run(3, 2);
    chk("walk_lamp", int'(walk), 1);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("ack_in_walk", int'(ped_ack), 0);
    run(3, 3); run(6, 1); run(0, 20);

    do_reset();
    side_car = 1'b1; ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("ack_combined", int'(ped_ack), 1);
    run(0, 7); run(1, 3);
    chk("allred_a", int'(phase), 2);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("ack_enter_walk", int'(ped_ack), 0);
    chk("walk_first", int'(phase), 3);
    run(3, 6);
    chk("side_after_walk", int'(phase), 4);
    side_car = 1'b0;
    run(4, 8); run(5, 3); run(6, 1); run(0, 12);

    do_reset();
    side_car = 1'b1;
    run(0, 8); run(1, 3); run(2, 1); run(4, 2);
    ped_req = 1'b1;
    step();
    ped_req = 1'b0;
    chk("ack_side_green", int'(ped_ack), 1);
    side_car = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_mid_phase", int'(phase), 0);
    chk("reset_mid_ack", int'(ped_ack), 0);
    run(0, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Sequences a two-road intersection (main road, side road) and a pedestrian crossing through a fixed ring of signal phases with parameterised, cycle-counted durations. Main road rests in green. The side-road car sensor and a latched pedestrian request pull the ring forward, subject to minimum and maximum green times. The block drives both roads' lamp sets and the walk signal directly, and replaces the single-road red/yellow/green controller at the intersection level.

## Interface
- MIN_GREEN, 8: minimum cycles of any green phase (main or side).
- MAX_GREEN, 16: maximum cycles of side green while side_car stays high.
- YELLOW, 3: cycles of each yellow phase.
- ALL_RED, 1: cycles of each all-red clearance phase.
- WALK, 6: cycles of the pedestrian walk phase.
- CNT_W, 5: phase timer width; all durations are ≥1 and ≤2^CNT_W; MIN_GREEN ≤ MAX_GREEN.
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- side_car  in  1  side-road vehicle present; level-sensed, not latched.
- ped_req  in  1  pedestrian button; any-cycle pulse, latched internally.
- main_red, main_yellow, main_green  out  1 each  main-road lamps.
- side_red, side_yellow, side_green  out  1 each  side-road lamps.
- walk  out  1  pedestrian walk lamp.
- ped_ack  out  1  one-cycle pulse when a pedestrian request is newly latched.
- phase  out  3  current phase code, for debug and verification.

## Operation
- Phase codes:
  - MAIN_GREEN = 0, MAIN_YELLOW = 1, ALL_RED_A = 2, WALK = 3.
  - SIDE_GREEN = 4, SIDE_YELLOW = 5, ALL_RED_B = 6.
  - 7 is illegal.
- Registered state: phase, timer[CNT_W-1:0], ped_pending, ped_ack.
- Timer:
  - Clears to 0 on every phase change; increments otherwise.
  - Saturates at 2^CNT_W-1.
  - A phase of duration D ends on the edge where timer == D-1, so it lasts exactly D cycles.
- Transitions:
  - MAIN_GREEN → MAIN_YELLOW when timer ≥ MIN_GREEN-1 and (side_car or ped_pending); otherwise stay, indefinitely.
  - MAIN_YELLOW → ALL_RED_A after YELLOW cycles.
  - ALL_RED_A → WALK if ped_pending, else → SIDE_GREEN, after ALL_RED cycles.
  - WALK → SIDE_GREEN if side_car, else → ALL_RED_B, after WALK cycles.
  - SIDE_GREEN → SIDE_YELLOW when (timer ≥ MIN_GREEN-1 and !side_car) or timer == MAX_GREEN-1.
  - SIDE_YELLOW → ALL_RED_B after YELLOW cycles.
  - ALL_RED_B → MAIN_GREEN after ALL_RED cycles.
  - Illegal phase (7) → MAIN_GREEN on the next edge with timer cleared; outputs show all-red while in 7.
- Pedestrian latch:
  - ped_pending sets on ped_req, except in WALK and except on the edge entering WALK. Both cases drop the request.
  - ped_pending clears on the edge entering WALK.
  - ped_ack = 1 for exactly the cycle after ped_pending goes 0→1. Repeated ped_req while already pending produces no further ack.
- Lamps are Moore decodes of phase only, with no combinational path from inputs:
  - Exactly one of main_red/yellow/green is high; likewise for the side lamps.
  - main_green only in phase 0; main_yellow only in phase 1; main_red otherwise.
  - side_green only in phase 4; side_yellow only in phase 5; side_red otherwise.
  - walk only in phase 3.

## Timing
- Reset values, visible the cycle after reset is sampled high:
  - phase = 0, timer = 0, ped_pending = 0, ped_ack = 0.
  - main_green = 1, side_red = 1, walk = 0.
- Reset mid-operation: reset wins over every transition and latch update in the same cycle.
- Input-to-phase latency is one edge: a request sampled on the edge where the minimum time expires changes phase at that same edge.
- Simultaneous side_car and ped_pending at ALL_RED_A: WALK is served first, then SIDE_GREEN if side_car is still high.
- ped_req and the edge entering WALK in the same cycle: the request is served by this WALK and no ack is issued.

## Test plan
- Idle: reset, then 100 cycles with no inputs → phase 0 throughout; main_green = 1, side_red = 1, walk = 0, ped_ack = 0.
- Side car held: side_car = 1 from the first cycle after reset → phase sequence 0×8, 1×3, 2×1, 4×16, 5×3, 6×1, then back to 0.
- Side car leaves early: side_car drops at side-green cycle 3 → side green lasts 8 cycles. Separately, a side_car pulse during main-green cycles 0–6 only → phase stays 0.
- Pedestrian request: ped_req pulse at cycle 3, side_car = 0.
  - ped_ack pulses at cycle 4.
  - Phases run 0×8, 1×3, 2×1, 3×6 (walk = 1), 6×1, then 0.
  - A second ped_req during WALK → no ack, no second walk.
- Combined: ped_req plus side_car held → phases 0×8, 1×3, 2×1, 3×6, then 4. ped_req at the cycle entering WALK → no ack.
- Reset and recovery:
  - reset asserted in SIDE_GREEN with ped_pending = 1 → next cycle phase 0, timer 0, pending 0; the ring does not advance without a new request.
  - Forcing phase to 7 → all-red for 1 cycle, then phase 0.
